// File: rtl/cmp_stim_checker.sv
// cmp_stim_checker: stimulus/response engine for a WIDTH-bit magnitude comparator.
// Drives LFSR-generated operands on a_out/b_out. One cycle later it samples the
// comparator's lt/gt/eq flags and checks them against an internal unsigned compare.
// It counts vectors and errors and records the operands of the first failing vector.
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   start                           pulse; begins a run from IDLE or DONE
//   a_out, b_out                    operands to the comparator
//   a_lt_b_in, a_gt_b_in, a_eq_b_in comparator flags
//   busy, done, pass                run status (done/pass held until next start)
//   vec_count, err_count            vectors checked / mismatches (saturating)
//   first_err_a, first_err_b        operands of the first failing vector
module cmp_stim_checker #(
  parameter int unsigned WIDTH       = 4,
  parameter int unsigned NUM_VECTORS = 16,
  parameter logic [15:0] SEED        = 16'hACE1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic [WIDTH-1:0] a_out,
  output logic [WIDTH-1:0] b_out,
  input  logic             a_lt_b_in,
  input  logic             a_gt_b_in,
  input  logic             a_eq_b_in,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [7:0]       vec_count,
  output logic [7:0]       err_count,
  output logic [WIDTH-1:0] first_err_a,
  output logic [WIDTH-1:0] first_err_b
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DRIVE  = 2'd1;
  localparam logic [1:0] ST_SAMPLE = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  // An all-zero seed would lock the LFSR, so it is replaced by 1.
  localparam logic [15:0] SEED_LOAD = (SEED == 16'h0000) ? 16'h0001 : SEED;
  localparam logic [7:0]  LAST_VEC  = 8'(NUM_VECTORS - 1);

  logic [1:0]       state, state_nx;
  logic [15:0]      lfsr, lfsr_nx, lfsr_step;
  logic [WIDTH-1:0] a_nx, b_nx, fa_nx, fb_nx;
  logic [WIDTH-1:0] raw_a, raw_b;
  logic [7:0]       vec_nx, err_nx;
  logic             busy_nx, done_nx, pass_nx;
  logic [2:0]       flags_exp, flags_got;
  logic             mismatch;

  // Fibonacci LFSR, taps 16,14,13,11, shifting left.
  assign lfsr_step = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  assign raw_a     = lfsr[WIDTH-1:0];
  assign raw_b     = lfsr[2*WIDTH-1:WIDTH];

  // Golden compare of the operands currently on the bus.
  assign flags_exp = {a_out < b_out, a_out > b_out, a_out == b_out};
  assign flags_got = {a_lt_b_in, a_gt_b_in, a_eq_b_in};
  assign mismatch  = (flags_got != flags_exp);

  // Next-state and datapath next values.
  always_comb begin
    state_nx = state;
    lfsr_nx  = lfsr;
    a_nx     = a_out;
    b_nx     = b_out;
    vec_nx   = vec_count;
    err_nx   = err_count;
    fa_nx    = first_err_a;
    fb_nx    = first_err_b;
    busy_nx  = (state == ST_DRIVE) || (state == ST_SAMPLE);
    done_nx  = 1'b0;
    pass_nx  = 1'b0;

    case (state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_nx = ST_DRIVE;
          lfsr_nx  = SEED_LOAD;
          vec_nx   = 8'd0;
          err_nx   = 8'd0;
          fa_nx    = '0;
          fb_nx    = '0;
        end else if (state == ST_DONE) begin
          done_nx = 1'b1;
          pass_nx = (err_count == 8'd0);
        end
      end
      ST_DRIVE: begin
        // Every fourth vector forces equality so the eq flag gets exercised.
        a_nx     = raw_a;
        b_nx     = (vec_count[1:0] == 2'd0) ? raw_a : raw_b;
        state_nx = ST_SAMPLE;
      end
      ST_SAMPLE: begin
        if (mismatch) begin
          if (err_count != 8'hFF) begin
            err_nx = err_count + 8'd1;
          end
          if (err_count == 8'd0) begin
            fa_nx = a_out;
            fb_nx = b_out;
          end
        end
        vec_nx   = vec_count + 8'd1;
        lfsr_nx  = lfsr_step;
        state_nx = (vec_count == LAST_VEC) ? ST_DONE : ST_DRIVE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      lfsr        <= SEED_LOAD;
      a_out       <= '0;
      b_out       <= '0;
      vec_count   <= 8'd0;
      err_count   <= 8'd0;
      first_err_a <= '0;
      first_err_b <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      pass        <= 1'b0;
    end else begin
      state       <= state_nx;
      lfsr        <= lfsr_nx;
      a_out       <= a_nx;
      b_out       <= b_nx;
      vec_count   <= vec_nx;
      err_count   <= err_nx;
      first_err_a <= fa_nx;
      first_err_b <= fb_nx;
      busy        <= busy_nx;
      done        <= done_nx;
      pass        <= pass_nx;
    end
  end

endmodule
